// File: rtl/add_pipe_arb_pkg.sv
// add_pipe_arb_pkg: shared FSM states and result tag type for the arbitrated adder
package add_pipe_arb_pkg;

   localparam int TAG_ID_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   typedef struct packed {
      logic                vld;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/add_pipe.sv
// add_pipe: signed adder with optional input stages and result pipeline stages, no reset
module add_pipe #(
   parameter int P_DATA_SIZE = 16,
   parameter int P_NUM_PIPE  = 2,
   parameter int P_IN_REG    = 0,
   parameter int P_OUT_REG   = 0
) (
   input  logic                   i_clk,
   input  logic                   i_vld,
   input  logic [P_DATA_SIZE-1:0] i_a,
   input  logic [P_DATA_SIZE-1:0] i_b,
   input  logic                   i_c,
   output logic                   o_vld,
   output logic [P_DATA_SIZE:0]   o_s
);

   localparam int W    = P_DATA_SIZE;
   localparam int IN_W = 2 * W + 2;
   localparam int RD   = P_NUM_PIPE + P_OUT_REG;

   logic [IN_W-1:0] in_bus, in_d;
   logic [W+1:0]    sum_bus, out_d;
   logic            dv, dc;
   logic [W-1:0]    da, db;

   assign in_bus = {i_vld, i_a, i_b, i_c};

   generate
      if (P_IN_REG == 0) begin : g_in_comb
         assign in_d = in_bus;
      end else begin : g_in_reg
         logic [IN_W-1:0] in_q [0:P_IN_REG-1];
         // operand register chain ahead of the adder
         always_ff @(posedge i_clk) begin
            in_q[0] <= in_bus;
            for (int k = 1; k < P_IN_REG; k++) in_q[k] <= in_q[k-1];
         end
         assign in_d = in_q[P_IN_REG-1];
      end
   endgenerate

   assign {dv, da, db, dc} = in_d;
   assign sum_bus = {dv, {da[W-1], da} + {db[W-1], db} + {{W{1'b0}}, dc}};

   generate
      if (RD == 0) begin : g_out_comb
         assign out_d = sum_bus;
      end else begin : g_out_reg
         logic [W+1:0] out_q [0:RD-1];
         // result register chain after the adder
         always_ff @(posedge i_clk) begin
            out_q[0] <= sum_bus;
            for (int k = 1; k < RD; k++) out_q[k] <= out_q[k-1];
         end
         assign out_d = out_q[RD-1];
      end
   endgenerate

   assign {o_vld, o_s} = out_d;

endmodule

// File: rtl/add_pipe_arb.sv
// add_pipe_arb: round-robin arbiter feeding one pipelined adder, results routed back by tag
module add_pipe_arb
   import add_pipe_arb_pkg::*;
#(
   parameter int P_DATA_SIZE = 16,
   parameter int P_NUM_REQ   = 4,
   parameter int P_NUM_PIPE  = 2,
   parameter int P_IN_REG    = 0,
   parameter int P_OUT_REG   = 0
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_en,
   input  logic [P_NUM_REQ-1:0]               i_req_vld,
   output logic [P_NUM_REQ-1:0]               o_req_rdy,
   input  logic [P_NUM_REQ*P_DATA_SIZE-1:0]   i_req_a,
   input  logic [P_NUM_REQ*P_DATA_SIZE-1:0]   i_req_b,
   input  logic [P_NUM_REQ-1:0]               i_req_c,
   output logic [P_NUM_REQ-1:0]               o_rsp_vld,
   output logic [P_DATA_SIZE:0]               o_rsp_s,
   output logic [$clog2(P_NUM_REQ)-1:0]       o_rsp_id,
   output logic                               o_busy,
   output logic [$clog2(P_NUM_PIPE+P_IN_REG+P_OUT_REG+1):0] o_inflight
);

   localparam int L  = P_NUM_PIPE + P_IN_REG + P_OUT_REG;
   localparam int W  = P_DATA_SIZE;
   localparam int IW = $clog2(P_NUM_REQ);
   localparam int CW = $clog2(L + 1) + 1;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d, gnt_id;
   logic [CW-1:0]   infl_q, infl_d;
   logic            found, xfer;
   logic [W-1:0]    add_a, add_b;
   logic            add_c, add_o_vld;
   logic [W:0]      add_s;
   tag_t            tag_in, tag_out;
   logic            unused_ok;
   int              idx;

   assign xfer   = (state_q == ST_RUN) && found;
   assign o_busy = (state_q != ST_IDLE);
   assign o_inflight = infl_q;
   assign unused_ok  = ^{add_o_vld, tag_out.id};

   // round-robin search for the first valid requester at or after the pointer
   always_comb begin
      found  = 1'b0;
      gnt_id = '0;
      idx    = 0;
      for (int k = 0; k < P_NUM_REQ; k++) begin
         idx = (int'(ptr_q) + k) % P_NUM_REQ;
         if (!found && i_req_vld[idx]) begin
            found  = 1'b1;
            gnt_id = IW'(idx);
         end
      end
   end

   // grant strobe, adder operand mux, tag launch and pointer/count next state
   always_comb begin
      o_req_rdy = '0;
      if (xfer) o_req_rdy[gnt_id] = 1'b1;
      add_a  = xfer ? i_req_a[gnt_id*W +: W] : '0;
      add_b  = xfer ? i_req_b[gnt_id*W +: W] : '0;
      add_c  = xfer ? i_req_c[gnt_id] : 1'b0;
      tag_in = '0;
      tag_in.vld = xfer;
      tag_in.id[IW-1:0] = gnt_id;
      ptr_d  = !xfer ? ptr_q : (gnt_id == IW'(P_NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      infl_d = infl_q + CW'(xfer) - CW'(tag_out.vld);
   end

   // FSM next state: leave DRAIN only once every issued result has come back
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (i_en) state_d = ST_RUN;
         ST_RUN:   if (!i_en) state_d = ST_DRAIN;
         ST_DRAIN: if (i_en) state_d = ST_RUN;
                   else if (infl_q == '0 && !xfer) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // state, round-robin pointer and in-flight counter registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         infl_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         infl_q  <= infl_d;
      end
   end

   generate
      if (L == 0) begin : g_tag_comb
         assign tag_out = tag_in;
      end else begin : g_tag_pipe
         tag_t tag_q [0:L-1];
         // tag delay line matched to the adder latency; reset drops in-flight tags
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               for (int k = 0; k < L; k++) tag_q[k] <= '0;
            end else begin
               tag_q[0] <= tag_in;
               for (int k = 1; k < L; k++) tag_q[k] <= tag_q[k-1];
            end
         end
         assign tag_out = tag_q[L-1];
      end
   endgenerate

   // result routing gated by the tag, since the adder pipeline holds stale data after reset
   always_comb begin
      o_rsp_vld = '0;
      if (tag_out.vld) o_rsp_vld[tag_out.id[IW-1:0]] = 1'b1;
      o_rsp_s  = tag_out.vld ? add_s : '0;
      o_rsp_id = tag_out.vld ? tag_out.id[IW-1:0] : '0;
   end

   add_pipe #(
      .P_DATA_SIZE (P_DATA_SIZE),
      .P_NUM_PIPE  (P_NUM_PIPE),
      .P_IN_REG    (P_IN_REG),
      .P_OUT_REG   (P_OUT_REG)
   ) u_add (
      .i_clk (i_clk),
      .i_vld (xfer),
      .i_a   (add_a),
      .i_b   (add_b),
      .i_c   (add_c),
      .o_vld (add_o_vld),
      .o_s   (add_s)
   );

endmodule

// File: tb/tb_add_pipe_arb.sv
// tb_add_pipe_arb: directed checks of arbitration, latency, drain and reset on L=2, L=3 and L=0 instances
module tb_add_pipe_arb;

   logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
   logic [3:0]  vld = '0, rc = '0;
   logic [63:0] ra = '0, rb = '0;

   logic [3:0]  rdy2, rsp_vld2, rdy3, rsp_vld3, rdy0, rsp_vld0;
   logic [16:0] rsp_s2, rsp_s3, rsp_s0;
   logic [1:0]  rsp_id2, rsp_id3, rsp_id0;
   logic        busy2, busy3, busy0;
   logic [2:0]  infl2, infl3;
   logic [0:0]  infl0;

   int total = 0, bad = 0;

   logic [16:0] es  [0:499];
   logic [1:0]  eid [0:499];

   always #5 clk = ~clk;

   add_pipe_arb u_l2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_req_vld(vld), .o_req_rdy(rdy2),
      .i_req_a(ra), .i_req_b(rb), .i_req_c(rc), .o_rsp_vld(rsp_vld2), .o_rsp_s(rsp_s2),
      .o_rsp_id(rsp_id2), .o_busy(busy2), .o_inflight(infl2));

   add_pipe_arb #(.P_NUM_PIPE(1), .P_IN_REG(1), .P_OUT_REG(1)) u_l3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_req_vld(vld), .o_req_rdy(rdy3),
      .i_req_a(ra), .i_req_b(rb), .i_req_c(rc), .o_rsp_vld(rsp_vld3), .o_rsp_s(rsp_s3),
      .o_rsp_id(rsp_id3), .o_busy(busy3), .o_inflight(infl3));

   add_pipe_arb #(.P_NUM_PIPE(0)) u_l0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_req_vld(vld), .o_req_rdy(rdy0),
      .i_req_a(ra), .i_req_b(rb), .i_req_c(rc), .o_rsp_vld(rsp_vld0), .o_rsp_s(rsp_s0),
      .o_rsp_id(rsp_id0), .o_busy(busy0), .o_inflight(infl0));

   task do_reset;
      @(negedge clk); rst_n = 1'b0; en = 1'b0; vld = '0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task test_reset;
      @(negedge clk); en = 1'b1; vld = 4'hF; ra = {4{16'h1111}}; rb = {4{16'h2222}}; rc = 4'hF;
      #1;
      total++; if (rdy2 !== 4'h0 || rdy0 !== 4'h0) begin bad++; $display("FAIL reset_rdy got=%h/%h exp=0", rdy2, rdy0); end
      total++; if (rsp_vld2 !== 4'h0 || rsp_vld0 !== 4'h0) begin bad++; $display("FAIL reset_rsp_vld got=%h/%h exp=0", rsp_vld2, rsp_vld0); end
      total++; if (rsp_s2 !== 17'h0 || rsp_id2 !== 2'd0 || rsp_s0 !== 17'h0) begin bad++; $display("FAIL reset_rsp_data got s=%h id=%h s0=%h exp=0", rsp_s2, rsp_id2, rsp_s0); end
      total++; if (busy2 !== 1'b0 || infl2 !== 3'd0 || infl3 !== 3'd0) begin bad++; $display("FAIL reset_busy_infl got busy=%b infl=%0d/%0d exp=0", busy2, infl2, infl3); end
   endtask

   task test_single;
      @(negedge clk); rst_n = 1'b1; vld = '0; en = 1'b1;
      @(negedge clk); vld = 4'b0001; ra[15:0] = 16'hFFFF; rb[15:0] = 16'h0000; rc = 4'b0001;
      #1;
      total++; if (rdy2 !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", rdy2); end
      @(negedge clk); vld = '0;
      #1;
      total++; if (infl2 !== 3'd1 || rsp_vld2 !== 4'h0) begin bad++; $display("FAIL single_wait got infl=%0d vld=%b exp 1/0000", infl2, rsp_vld2); end
      @(negedge clk); #1;
      total++; if (rsp_vld2 !== 4'b0001 || rsp_s2 !== 17'h0 || rsp_id2 !== 2'd0) begin bad++; $display("FAIL single_rsp got vld=%b s=%h id=%0d exp 0001/0/0", rsp_vld2, rsp_s2, rsp_id2); end
      @(negedge clk); #1;
      total++; if (rsp_vld2 !== 4'h0 || infl2 !== 3'd0 || rsp_s2 !== 17'h0) begin bad++; $display("FAIL single_after got vld=%b infl=%0d s=%h exp 0000/0/0", rsp_vld2, infl2, rsp_s2); end
   endtask

   task test_l0;
      @(negedge clk); vld = 4'b0100; ra[47:32] = 16'h7FFF; rb[47:32] = 16'h0001; rc = 4'b0000;
      #1;
      total++; if (rdy0 !== 4'b0100) begin bad++; $display("FAIL l0_grant got=%b exp=0100", rdy0); end
      total++; if (rsp_vld0 !== 4'b0100 || rsp_s0 !== 17'h08000 || rsp_id0 !== 2'd2) begin bad++; $display("FAIL l0_rsp got vld=%b s=%h id=%0d exp 0100/08000/2", rsp_vld0, rsp_s0, rsp_id0); end
      @(negedge clk); vld = '0;
      #1;
      total++; if (rsp_vld0 !== 4'h0 || rsp_s0 !== 17'h0 || infl0 !== 1'b0) begin bad++; $display("FAIL l0_after got vld=%b s=%h infl=%0d exp 0", rsp_vld0, rsp_s0, infl0); end
   endtask

   task test_fairness;
      do_reset();
      @(negedge clk); en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); vld = 4'hF;
         #1;
         total++; if (rdy2 !== 4'(1 << (i % 4))) begin bad++; $display("FAIL fair_grant%0d got=%b exp=%b", i, rdy2, 4'(1 << (i % 4))); end
      end
      @(negedge clk); vld = '0;
   endtask

   task test_back_to_back;
      int p, w, peak;
      logic [3:0]  m;
      logic [15:0] a, b;
      do_reset();
      @(negedge clk); en = 1'b1;
      p = 0; peak = 0;
      for (int n = 0; n < 504; n++) begin
         @(negedge clk);
         m = '0;
         if (n < 500) begin
            m = 4'($urandom_range(1, 15));
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 4'($urandom);
         end
         vld = m;
         #1;
         w = -1;
         for (int k = 0; k < 4; k++) if (w < 0 && m[(p + k) % 4]) w = (p + k) % 4;
         total++;
         if (w < 0) begin
            if (rdy3 !== 4'h0) begin bad++; $display("FAIL b2b_idle_grant n=%0d got=%b exp=0000", n, rdy3); end
         end else begin
            if (rdy3 !== 4'(1 << w)) begin bad++; $display("FAIL b2b_grant n=%0d got=%b exp=%b", n, rdy3, 4'(1 << w)); end
            a = ra[w*16 +: 16]; b = rb[w*16 +: 16];
            es[n]  = {a[15], a} + {b[15], b} + {16'h0, rc[w]};
            eid[n] = 2'(w);
            p = (w + 1) % 4;
         end
         total++;
         if (n >= 3 && n < 503) begin
            if (rsp_vld3 !== 4'(1 << eid[n-3]) || rsp_s3 !== es[n-3] || rsp_id3 !== eid[n-3]) begin
               bad++; $display("FAIL b2b_rsp n=%0d got vld=%b s=%h id=%0d exp vld=%b s=%h id=%0d", n, rsp_vld3, rsp_s3, rsp_id3, 4'(1 << eid[n-3]), es[n-3], eid[n-3]);
            end
         end else if (rsp_vld3 !== 4'h0) begin
            bad++; $display("FAIL b2b_spurious n=%0d got=%b exp=0000", n, rsp_vld3);
         end
         if (int'(infl3) > peak) peak = int'(infl3);
      end
      total++; if (peak !== 3) begin bad++; $display("FAIL b2b_peak got=%0d exp=3", peak); end
   endtask

   task test_drain;
      @(negedge clk); vld = 4'b0001; ra[15:0] = 16'h1234; rb[15:0] = 16'h0100; rc = 4'b0000;
      #1;
      total++; if (rdy2 !== 4'b0001) begin bad++; $display("FAIL drain_g0 got=%b exp=0001", rdy2); end
      @(negedge clk); vld = 4'b0010; ra[31:16] = 16'h8000; rb[31:16] = 16'h8000; rc = 4'b0010; en = 1'b0;
      #1;
      total++; if (rdy2 !== 4'b0010) begin bad++; $display("FAIL drain_g1 got=%b exp=0010", rdy2); end
      @(negedge clk); vld = 4'hF;
      #1;
      total++; if (rdy2 !== 4'h0 || busy2 !== 1'b1 || infl2 !== 3'd2) begin bad++; $display("FAIL drain_d2 got rdy=%b busy=%b infl=%0d exp 0000/1/2", rdy2, busy2, infl2); end
      total++; if (rsp_vld2 !== 4'b0001 || rsp_s2 !== 17'h01334 || rsp_id2 !== 2'd0) begin bad++; $display("FAIL drain_rsp0 got vld=%b s=%h id=%0d exp 0001/01334/0", rsp_vld2, rsp_s2, rsp_id2); end
      @(negedge clk); #1;
      total++; if (rdy2 !== 4'h0 || busy2 !== 1'b1 || infl2 !== 3'd1) begin bad++; $display("FAIL drain_d3 got rdy=%b busy=%b infl=%0d exp 0000/1/1", rdy2, busy2, infl2); end
      total++; if (rsp_vld2 !== 4'b0010 || rsp_s2 !== 17'h10001 || rsp_id2 !== 2'd1) begin bad++; $display("FAIL drain_rsp1 got vld=%b s=%h id=%0d exp 0010/10001/1", rsp_vld2, rsp_s2, rsp_id2); end
      @(negedge clk); #1;
      total++; if (busy2 !== 1'b1 || infl2 !== 3'd0 || rsp_vld2 !== 4'h0 || rdy2 !== 4'h0) begin bad++; $display("FAIL drain_d4 got busy=%b infl=%0d vld=%b rdy=%b exp 1/0/0000/0000", busy2, infl2, rsp_vld2, rdy2); end
      @(negedge clk); en = 1'b1;
      #1;
      total++; if (busy2 !== 1'b0 || rdy2 !== 4'h0) begin bad++; $display("FAIL drain_idle got busy=%b rdy=%b exp 0/0000", busy2, rdy2); end
   endtask

   task test_reset_midflight;
      @(negedge clk); #1;
      total++; if (rdy2 !== 4'b0100) begin bad++; $display("FAIL held_grant got=%b exp=0100", rdy2); end
      @(negedge clk); #1;
      total++; if (rdy2 !== 4'b1000) begin bad++; $display("FAIL held_grant2 got=%b exp=1000", rdy2); end
      @(negedge clk); rst_n = 1'b0;
      #1;
      total++; if (rdy2 !== 4'h0 || rsp_vld2 !== 4'h0 || rsp_s2 !== 17'h0 || rsp_id2 !== 2'd0 || busy2 !== 1'b0 || infl2 !== 3'd0) begin
         bad++; $display("FAIL midrst_out got rdy=%b vld=%b s=%h id=%0d busy=%b infl=%0d exp all 0", rdy2, rsp_vld2, rsp_s2, rsp_id2, busy2, infl2);
      end
      @(negedge clk); rst_n = 1'b1; en = 1'b0; vld = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         total++; if (rsp_vld2 !== 4'h0 || rsp_vld3 !== 4'h0 || rsp_s2 !== 17'h0 || busy2 !== 1'b0 || infl2 !== 3'd0) begin
            bad++; $display("FAIL midrst_after%0d got vld=%b/%b s=%h busy=%b infl=%0d exp all 0", i, rsp_vld2, rsp_vld3, rsp_s2, busy2, infl2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_l0();
      test_fairness();
      test_back_to_back();
      test_drain();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
